// File: rtl/ahb_cmd_seq_master_if.sv
// rtl/ahb_cmd_seq_master_if.sv - command/response and AHB3-Lite signal bundle for ahb_cmd_seq_master
// Check ports (cmd_exp_i, cmd_chk_i, mismatch_o, err_cnt_o) exist only with AHB_SEQ_CHECK_EN.
interface ahb_cmd_seq_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic              cmd_write_i;
  logic [2:0]        cmd_size_i;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              busy_o;
  logic              mHSEL;
  logic [ADDR_W-1:0] mHADDR;
  logic [DATA_W-1:0] mHWDATA;
  logic              mHWRITE;
  logic [2:0]        mHSIZE;
  logic [2:0]        mHBURST;
  logic [3:0]        mHPROT;
  logic [1:0]        mHTRANS;
  logic              mHREADY;
  logic [DATA_W-1:0] mHRDATA;
  logic              mHRESP;
`ifdef AHB_SEQ_CHECK_EN
  logic [DATA_W-1:0] cmd_exp_i;
  logic              cmd_chk_i;
  logic              mismatch_o;
  logic [15:0]       err_cnt_o;
`endif

  modport master (
`ifdef AHB_SEQ_CHECK_EN
    input  cmd_exp_i, cmd_chk_i,
    output mismatch_o, err_cnt_o,
`endif
    input  cmd_valid_i, cmd_addr_i, cmd_wdata_i, cmd_write_i, cmd_size_i,
    input  mHREADY, mHRDATA, mHRESP,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
    output mHSEL, mHADDR, mHWDATA, mHWRITE, mHSIZE, mHBURST, mHPROT, mHTRANS
  );

  modport slave (
`ifdef AHB_SEQ_CHECK_EN
    output cmd_exp_i, cmd_chk_i,
    input  mismatch_o, err_cnt_o,
`endif
    output cmd_valid_i, cmd_addr_i, cmd_wdata_i, cmd_write_i, cmd_size_i,
    output mHREADY, mHRDATA, mHRESP,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
    input  mHSEL, mHADDR, mHWDATA, mHWRITE, mHSIZE, mHBURST, mHPROT, mHTRANS
  );
endinterface

// File: rtl/ahb_cmd_seq_master.sv
// rtl/ahb_cmd_seq_master.sv - AHB3-Lite master replaying queued single-beat commands in order
// Optional read-data checker and error counter enabled by AHB_SEQ_CHECK_EN.
module ahb_cmd_seq_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  ahb_cmd_seq_master_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_ERR1, ST_ERR2} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_fifo_addr  [DEPTH];
  logic [DATA_W-1:0] r_fifo_wdata [DEPTH];
  logic              r_fifo_write [DEPTH];
  logic [2:0]        r_fifo_size  [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [PW:0]       r_count;
  logic              r_dp_valid;
  logic              r_dp_write;
  logic [DATA_W-1:0] r_dp_wdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic w_empty, w_full, w_push, w_pop, w_nonseq, w_done, w_err_done;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_FULL);
  assign w_push     = bus.cmd_valid_i && !w_full;
  // ERR1 withdraws the pending address so the slave's second error cycle sees IDLE.
  assign w_nonseq   = !w_empty && (r_state != ST_ERR1);
  assign w_pop      = w_nonseq && bus.mHREADY;
  assign w_done     = r_dp_valid && bus.mHREADY;
  assign w_err_done = w_done && (bus.mHRESP || (r_state == ST_ERR1));

  assign bus.cmd_ready_o = !w_full;
  assign bus.mHSEL       = w_nonseq;
  assign bus.mHTRANS     = w_nonseq ? 2'b10 : 2'b00;
  assign bus.mHADDR      = w_nonseq ? r_fifo_addr[r_rptr] : '0;
  assign bus.mHWRITE     = w_nonseq ? r_fifo_write[r_rptr] : 1'b0;
  assign bus.mHSIZE      = w_nonseq ? r_fifo_size[r_rptr] : 3'b000;
  assign bus.mHBURST     = 3'b000;
  assign bus.mHPROT      = 4'b0011;
  assign bus.mHWDATA     = r_dp_wdata;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.busy_o      = !w_empty || r_dp_valid || (r_state != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_addr[r_wptr]  <= bus.cmd_addr_i;
      r_fifo_wdata[r_wptr] <= bus.cmd_wdata_i;
      r_fifo_write[r_wptr] <= bus.cmd_write_i;
      r_fifo_size[r_wptr]  <= bus.cmd_size_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_dp_valid  <= 1'b0;
      r_dp_write  <= 1'b0;
      r_dp_wdata  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase

      if (bus.mHREADY) begin
        r_dp_valid <= w_nonseq;
        if (w_nonseq) begin
          r_dp_write <= r_fifo_write[r_rptr];
          r_dp_wdata <= r_fifo_wdata[r_rptr];
        end
      end

      r_rsp_valid <= w_done;
      r_rsp_rdata <= (w_done && !r_dp_write) ? bus.mHRDATA : '0;
      r_rsp_err   <= w_err_done;

      case (r_state)
        ST_IDLE:   if (!w_empty) r_state <= ST_ACTIVE;
        ST_ACTIVE: begin
          if (r_dp_valid && bus.mHRESP && !bus.mHREADY) r_state <= ST_ERR1;
          else if (w_empty && !r_dp_valid)              r_state <= ST_IDLE;
        end
        ST_ERR1:   if (bus.mHREADY) r_state <= ST_ERR2;
        ST_ERR2:   r_state <= (!w_empty || r_dp_valid) ? ST_ACTIVE : ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef AHB_SEQ_CHECK_EN
  logic [DATA_W-1:0] r_fifo_exp [DEPTH];
  logic              r_fifo_chk [DEPTH];
  logic [DATA_W-1:0] r_dp_exp;
  logic              r_dp_chk;
  logic              r_mismatch;
  logic [15:0]       r_err_cnt;
  logic              w_mis;
  logic [16:0]       w_cnt_sum;

  assign w_mis     = w_done && !r_dp_write && r_dp_chk && (bus.mHRDATA != r_dp_exp);
  assign w_cnt_sum = 17'(r_err_cnt) + 17'(w_mis) + 17'(w_err_done);
  assign bus.mismatch_o = r_mismatch;
  assign bus.err_cnt_o  = r_err_cnt;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_exp[r_wptr] <= bus.cmd_exp_i;
      r_fifo_chk[r_wptr] <= bus.cmd_chk_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_dp_exp   <= '0;
      r_dp_chk   <= 1'b0;
      r_mismatch <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      if (bus.mHREADY && w_nonseq) begin
        r_dp_exp <= r_fifo_exp[r_rptr];
        r_dp_chk <= r_fifo_chk[r_rptr];
      end
      if (w_mis) r_mismatch <= 1'b1;
      r_err_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
  end
`endif
endmodule

// File: tb/tb_ahb_cmd_seq_master.sv
// tb/tb_ahb_cmd_seq_master.sv - randomized bench with SRAM slave and in-order response scoreboard
// Also exercises the AHB_SEQ_CHECK_EN ports when that macro is defined.
module tb_ahb_cmd_seq_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int LIMIT = 3000;

  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic write; logic [2:0] size; } cmd_t;
  typedef struct { logic [31:0] rdata; logic err; } rsp_t;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  ahb_cmd_seq_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  ahb_cmd_seq_master #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  cmd_t issue_q[$];
  rsp_t exp_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  bit stall = 0;
  int wait_sel = 0;
  int acc_n = 0, rsp_n = 0, err_seen = 0, err_total = 0, rsp_cyc_first = 0;
  int acc_cyc [256];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit in_err(input logic [31:0] a);
    return a[31:12] == 20'h1;
  endfunction

  function automatic int pick_wait(input int idx);
    if (wait_sel == 1) return (idx == 2) ? 2 : 0;
    if (wait_sel == 2) return $urandom_range(0, 2);
    return 0;
  endfunction

  // Commands complete strictly in order, so the expected response is fixed at push time.
  task automatic model_accept(input cmd_t c, output rsp_t r);
    r.err = in_err(c.addr);
    r.rdata = 32'h0;
    if (!r.err) begin
      if (c.write) ref_mem[c.addr] = c.wdata;
      else r.rdata = ref_mem.exists(c.addr) ? ref_mem[c.addr] : 32'h0;
    end
    issue_q.push_back(c);
    exp_q.push_back(r);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [2:0] s);
    cmd_t c;
    rsp_t r;
    int n = 0;
    c.addr = a; c.wdata = d; c.write = w; c.size = s;
    bus.cmd_valid_i = 1'b1; bus.cmd_addr_i = a; bus.cmd_wdata_i = d;
    bus.cmd_write_i = w; bus.cmd_size_i = s;
    while (!bus.cmd_ready_o && n < LIMIT) begin @(negedge clk_i); n++; end
    if (n >= LIMIT) check_eq("push_timeout", bus.cmd_ready_o, 1);
    model_accept(c, r);
`ifdef AHB_SEQ_CHECK_EN
    bus.cmd_exp_i = r.rdata;
    bus.cmd_chk_i = !w;
`endif
    @(negedge clk_i);
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic start_phase(input int ws);
    wait_sel = ws; acc_n = 0; rsp_n = 0; err_seen = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy_o) && n < LIMIT) begin @(negedge clk_i); n++; end
    check_eq("drain_done", n < LIMIT, 1);
  endtask

  // SRAM slave: decides each cycle's HREADY/HRESP at the negedge, commits what the next posedge will see.
  initial begin : slave
    bit dp_act = 0, dp_err = 0, err_stage = 0, hold_prev = 0, rdy, resp;
    int dp_wait = 0;
    logic [31:0] dp_addr, dp_wexp, hold_addr;
    logic dp_write;
    cmd_t c;
    bus.mHREADY = 1'b1; bus.mHRESP = 1'b0; bus.mHRDATA = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        dp_act = 0; hold_prev = 0; bus.mHREADY = 1'b1; bus.mHRESP = 1'b0;
        continue;
      end
      rdy = 1; resp = 0;
      bus.mHRDATA = $urandom;
      if (stall) rdy = 0;
      else if (dp_act) begin
        if (dp_wait > 0) begin rdy = 0; dp_wait--; end
        else if (dp_err) begin
          resp = 1;
          if (!err_stage) begin rdy = 0; err_stage = 1; end
          else bus.mHRDATA = '0;
        end else if (!dp_write) bus.mHRDATA = slv_mem.exists(dp_addr) ? slv_mem[dp_addr] : 32'h0;
      end
      bus.mHREADY = rdy; bus.mHRESP = resp;
      if (dp_act && dp_write) check_eq("hwdata", bus.mHWDATA, dp_wexp);
      if (hold_prev) begin
        check_eq("hold_htrans", bus.mHTRANS, 2'b10);
        check_eq("hold_haddr", bus.mHADDR, hold_addr);
      end
      hold_prev = (bus.mHTRANS == 2'b10) && !rdy && !resp;
      hold_addr = bus.mHADDR;
      if (rdy) begin
        if (dp_act && resp) check_eq("err2_htrans", bus.mHTRANS, 2'b00);
        if (dp_act && dp_write && !dp_err) slv_mem[dp_addr] = bus.mHWDATA;
        dp_act = 0;
        if (bus.mHTRANS == 2'b10) begin
          check_eq("acc_expected", issue_q.size() != 0, 1);
          if (issue_q.size() != 0) begin
            c = issue_q.pop_front();
            check_eq("haddr", bus.mHADDR, c.addr);
            check_eq("hwrite", bus.mHWRITE, c.write);
            check_eq("hsize", bus.mHSIZE, c.size);
            check_eq("hsel", bus.mHSEL, 1);
            dp_act = 1; dp_addr = bus.mHADDR; dp_write = bus.mHWRITE; dp_wexp = c.wdata;
            dp_err = in_err(bus.mHADDR); err_stage = 0; dp_wait = pick_wait(acc_n);
            if (acc_n < 256) acc_cyc[acc_n] = cyc;
            acc_n++;
          end
        end
      end
    end
  end

  initial begin : rsp_mon
    rsp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_n_i && bus.rsp_valid_o) begin
        check_eq("rsp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("rsp_rdata", bus.rsp_rdata_o, e.rdata);
          check_eq("rsp_err", bus.rsp_err_o, e.err);
        end
        if (rsp_n == 0) rsp_cyc_first = cyc;
        rsp_n++;
        if (bus.rsp_err_o) begin err_seen++; err_total++; end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] addrs [11];
    logic [31:0] vals [11];
    logic [31:0] a;
    int ncmd;
    bus.cmd_valid_i = 0; bus.cmd_addr_i = '0; bus.cmd_wdata_i = '0;
    bus.cmd_write_i = 0; bus.cmd_size_i = '0;
`ifdef AHB_SEQ_CHECK_EN
    bus.cmd_exp_i = '0; bus.cmd_chk_i = 0;
`endif
    repeat (3) @(negedge clk_i);
    check_eq("rst_htrans", bus.mHTRANS, 0);
    check_eq("rst_hsel", bus.mHSEL, 0);
    check_eq("rst_rsp_valid", bus.rsp_valid_o, 0);
    check_eq("rst_busy", bus.busy_o, 0);
    check_eq("rst_cmd_ready", bus.cmd_ready_o, 1);
    check_eq("rst_hwdata", bus.mHWDATA, 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // 11 zero-wait writes
    start_phase(0);
    for (int i = 0; i < 11; i++) begin
      addrs[i] = (i == 10) ? 32'h40 : 32'(i * 4);
      vals[i] = $urandom;
    end
    vals[8] = 32'h000FE039;
    vals[9] = 32'h00040008;
    push(addrs[0], vals[0], 1, 3'b010);
    check_eq("lat_nonseq", bus.mHTRANS, 2'b10);
    for (int i = 1; i < 11; i++) push(addrs[i], vals[i], 1, 3'b010);
    drain();
    check_eq("w_acc_n", acc_n, 11);
    check_eq("w_rsp_n", rsp_n, 11);
    check_eq("w_back2back", acc_cyc[10] - acc_cyc[0], 10);
    check_eq("w_rsp_lat", rsp_cyc_first - acc_cyc[0], 2);
    check_eq("w_err_n", err_seen, 0);

    // readback
    start_phase(0);
    for (int i = 0; i < 11; i++) push(addrs[i], $urandom, 0, 3'b010);
    drain();
    check_eq("r_rsp_n", rsp_n, 11);

    // two wait states on the third beat
    start_phase(1);
    for (int i = 0; i < 5; i++) push(32'h80 + 32'(i * 4), $urandom, 1, 3'b010);
    drain();
    check_eq("ws_beat3_gap", acc_cyc[2] - acc_cyc[1], 1);
    check_eq("ws_beat4_gap", acc_cyc[3] - acc_cyc[2], 3);
    check_eq("ws_rsp_n", rsp_n, 5);

    // error response followed by a queued write
    start_phase(0);
    push(32'h1000, 32'hDEADBEEF, 1, 3'b010);
    push(32'h04, 32'h5A5A0404, 1, 3'b010);
    push(32'h04, 32'h0, 0, 3'b010);
    drain();
    check_eq("e_err_n", err_seen, 1);
    check_eq("e_rsp_n", rsp_n, 3);

    // fill the FIFO while the bus is stalled
    start_phase(0);
    stall = 1;
    for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(i * 4), $urandom, 1, 3'b010);
    check_eq("full_ready", bus.cmd_ready_o, 0);
    check_eq("full_busy", bus.busy_o, 1);
    bus.cmd_valid_i = 1; bus.cmd_addr_i = 32'h200; bus.cmd_wdata_i = 32'h17171717;
    bus.cmd_write_i = 1; bus.cmd_size_i = 3'b010;
    repeat (3) begin
      @(negedge clk_i);
      check_eq("full_refuse", bus.cmd_ready_o, 0);
    end
    stall = 0;
    push(32'h200, 32'h17171717, 1, 3'b010);
    drain();
    check_eq("full_rsp_n", rsp_n, DEPTH + 1);

    // asynchronous reset with commands queued
    stall = 1;
    for (int i = 0; i < 3; i++) push(32'h300 + 32'(i * 4), $urandom, 1, 3'b010);
    #2 rst_n_i = 1'b0;
    #1;
    check_eq("arst_htrans", bus.mHTRANS, 0);
    check_eq("arst_busy", bus.busy_o, 0);
    check_eq("arst_ready", bus.cmd_ready_o, 1);
    check_eq("arst_rsp_valid", bus.rsp_valid_o, 0);
    issue_q.delete();
    exp_q.delete();
    ref_mem = slv_mem;
    stall = 0;
    err_total = 0;
    start_phase(0);
    @(negedge clk_i);
    #2 rst_n_i = 1'b1;
    repeat (10) @(negedge clk_i);
    check_eq("arst_no_rsp", rsp_n, 0);
    check_eq("arst_busy_after", bus.busy_o, 0);
    check_eq("arst_ready_after", bus.cmd_ready_o, 1);

    // randomized traffic with random wait states and gaps
    start_phase(2);
    ncmd = 150;
    for (int i = 0; i < ncmd; i++) begin
      a = ($urandom_range(0, 15) == 0) ? 32'h1000 + 32'($urandom_range(0, 15) * 4)
                                       : 32'($urandom_range(0, 15) * 4);
      push(a, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_i);
    end
    drain();
    check_eq("rnd_rsp_n", rsp_n, ncmd);
    check_eq("rnd_idle_busy", bus.busy_o, 0);
`ifdef AHB_SEQ_CHECK_EN
    check_eq("chk_mismatch", bus.mismatch_o, 0);
    check_eq("chk_err_cnt", bus.err_cnt_o, err_total);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
